// File: rtl/decode_arbiter.sv
// decode_arbiter
//
// Four requesters share one lookup decoder. Each entry maps a 2-bit code
// to a 17-bit value. Requests are granted in round-robin order and served
// one at a time. Each result is tagged with the requester index and held
// under a valid/ready handshake until the consumer takes it. The lookup
// table can be rewritten at run time. On reset it returns to the binary
// digit mapping 0,1,0,1.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   req       per-requester request level, held until granted
//   code      packed codes; requester i uses bits [2i+1:2i]
//   grant     one-hot, one-cycle pulse in the cycle after acceptance
//   cfgWe     table write enable
//   cfgAddr   table entry to write
//   cfgData   value written to entry cfgAddr
//   out       decoded value
//   outId     index of the requester that owns out
//   outValid  out/outId valid
//   outReady  consumer accepts out when high while outValid is high
//   busy      high whenever the sequencer is not idle
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | sample req; pick a round-robin winner and latch its code/id
// LOOKUP | grant pulse is visible; the table read lands in out/outId
// RESP   | hold out/outId/outValid until outReady completes handshake

module decode_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CODE_W  = 2,
    parameter int OUT_W   = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*CODE_W-1:0] code,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      cfgWe,
    input  logic [CODE_W-1:0]         cfgAddr,
    input  logic [OUT_W-1:0]          cfgData,
    output logic [OUT_W-1:0]          out,
    output logic [1:0]                outId,
    output logic                      outValid,
    input  logic                      outReady,
    output logic                      busy
);

    localparam int ID_W    = 2;
    localparam int TBL_LEN = 1 << CODE_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    win_id;
    logic [CODE_W-1:0]  win_code;

    logic               sel_found;
    logic [ID_W-1:0]    sel_id;
    logic [CODE_W-1:0]  sel_code;

    logic [NUM_REQ-1:0] grant_next;
    logic               load_win;
    logic               load_out;
    logic               release_out;

    logic [OUT_W-1:0]   lut [TBL_LEN];

    // Round-robin search. It starts at ptr and the index wraps through
    // the 2-bit add. The first active request found wins.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!sel_found && req[ID_W'(ptr + ID_W'(i))]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(ptr + ID_W'(i));
            end
        end
        sel_code = code[sel_id*CODE_W +: CODE_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant_next  = '0;
        load_win    = 1'b0;
        load_out    = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_next = NUM_REQ'(1) << sel_id;
                    load_win   = 1'b1;
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                load_out   = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (outReady) begin
                    release_out = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The table read in LOOKUP and a same-edge cfg write are both
    // non-blocking. So out takes the pre-write entry, and the new value
    // is seen only by later lookups.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant    <= '0;
            ptr      <= '0;
            win_id   <= '0;
            win_code <= '0;
            out      <= '0;
            outId    <= '0;
            outValid <= 1'b0;
            for (int i = 0; i < TBL_LEN; i++) begin
                lut[i] <= OUT_W'(i & 1);
            end
        end else begin
            grant <= grant_next;
            if (load_win) begin
                win_id   <= sel_id;
                win_code <= sel_code;
            end
            if (load_out) begin
                out      <= lut[win_code];
                outId    <= win_id;
                outValid <= 1'b1;
                ptr      <= ID_W'(win_id + 1'b1);
            end
            if (release_out) begin
                outValid <= 1'b0;
            end
            if (cfgWe) begin
                lut[cfgAddr] <= cfgData;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_decode_arbiter.sv
// Testbench for decode_arbiter.
// A transaction-level reference model tracks the table contents, the
// round-robin pointer and how far the current request has progressed.
// The DUT outputs are compared against it every cycle. A directed scenario
// list with literal expectations is followed by randomized traffic.

module tb_decode_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  code;
    logic [3:0]  grant;
    logic        cfgWe;
    logic [1:0]  cfgAddr;
    logic [16:0] cfgData;
    logic [16:0] out;
    logic [1:0]  outId;
    logic        outValid;
    logic        outReady;
    logic        busy;

    int tests = 0;
    int fails = 0;

    decode_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .code     (code),
        .grant    (grant),
        .cfgWe    (cfgWe),
        .cfgAddr  (cfgAddr),
        .cfgData  (cfgData),
        .out      (out),
        .outId    (outId),
        .outValid (outValid),
        .outReady (outReady),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model.
    // m_age counts progress through a request:
    //   -1 = no request in flight
    //    0 = granted this cycle
    //    1 = result delivered and held
    logic [16:0] m_tbl [4];
    int          m_ptr;
    int          m_age;
    int          m_win;
    logic [1:0]  m_code;
    bit          m_live = 1'b0;
    logic [3:0]  e_grant;
    logic [16:0] e_out;
    logic [1:0]  e_id;
    logic        e_valid;
    logic        e_busy;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) m_tbl[k] = 17'(k % 2);
            m_ptr   = 0;
            m_age   = -1;
            e_grant = '0;
            e_out   = '0;
            e_id    = '0;
            e_valid = 1'b0;
            e_busy  = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            e_grant = '0;
            if (m_age < 0) begin
                m_win = -1;
                for (int k = 0; k < 4; k++)
                    if (m_win < 0 && req[(m_ptr + k) % 4]) m_win = (m_ptr + k) % 4;
                if (m_win >= 0) begin
                    e_grant = 4'(1 << m_win);
                    m_code  = code[2*m_win +: 2];
                    m_age   = 0;
                end
            end else if (m_age == 0) begin
                e_out   = m_tbl[m_code];
                e_id    = 2'(m_win);
                e_valid = 1'b1;
                m_ptr   = (m_win + 1) % 4;
                m_age   = 1;
            end else if (outReady) begin
                e_valid = 1'b0;
                m_age   = -1;
            end
            if (cfgWe) m_tbl[cfgAddr] = cfgData;
            e_busy = (m_age >= 0);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("mdl_grant", grant, e_grant);
            chk("mdl_valid", outValid, e_valid);
            chk("mdl_busy", busy, e_busy);
            if (e_valid) begin
                chk("mdl_out", out, e_out);
                chk("mdl_id", outId, e_id);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic serve(input logic [3:0] rq, input logic [7:0] cd,
                         input logic [3:0] xg, input logic [16:0] xo, input logic [1:0] xid);
        req      = rq;
        code     = cd;
        outReady = 1'b1;
        tick();
        chk("srv_grant", grant, xg);
        chk("srv_lookup_valid", outValid, 1'b0);
        chk("srv_lookup_busy", busy, 1'b1);
        req = '0;
        tick();
        chk("srv_out", out, xo);
        chk("srv_id", outId, xid);
        chk("srv_valid", outValid, 1'b1);
        chk("srv_gap_grant", grant, 4'b0000);
        tick();
        chk("srv_done_valid", outValid, 1'b0);
        chk("srv_done_busy", busy, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        code     = '0;
        cfgWe    = 1'b0;
        cfgAddr  = '0;
        cfgData  = '0;
        outReady = 1'b1;
        tick();
        tick();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_out", out, 17'h0);
        chk("rst_id", outId, 2'd0);
        chk("rst_valid", outValid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // Default table: code 11 decodes to 1.
        serve(4'b0001, 8'b0000_0011, 4'b0001, 17'd1, 2'd0);

        // Round-robin from ptr 0 with all four requesting.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++)
            serve(4'b1111, 8'b11_10_01_00, 4'(1 << (k % 4)), 17'(k % 2), 2'(k % 4));

        // Runtime configuration of entry 10.
        cfgWe   = 1'b1;
        cfgAddr = 2'd2;
        cfgData = 17'h1ABCD;
        tick();
        cfgWe = 1'b0;
        serve(4'b0100, 8'b0010_0000, 4'b0100, 17'h1ABCD, 2'd2);
        serve(4'b0001, 8'b0000_0000, 4'b0001, 17'd0, 2'd0);
        serve(4'b0001, 8'b0000_0001, 4'b0001, 17'd1, 2'd0);
        serve(4'b0001, 8'b0000_0011, 4'b0001, 17'd1, 2'd0);

        // A write landing in the LOOKUP cycle: out keeps the old value.
        req      = 4'b0010;
        code     = 8'b0000_0100;
        outReady = 1'b1;
        tick();
        chk("col_grant", grant, 4'b0010);
        req     = '0;
        cfgWe   = 1'b1;
        cfgAddr = 2'd1;
        cfgData = 17'h00005;
        tick();
        cfgWe = 1'b0;
        chk("col_out_old", out, 17'd1);
        chk("col_id", outId, 2'd1);
        tick();
        serve(4'b0010, 8'b0000_0100, 4'b0010, 17'd5, 2'd1);

        // Back-pressure. ptr is now 2, so requester 0 wins via wrap-around.
        req      = 4'b0001;
        code     = 8'b0000_0011;
        outReady = 1'b0;
        tick();
        chk("bp_grant", grant, 4'b0001);
        req = 4'b1111;
        tick();
        chk("bp_out", out, 17'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_hold_out", out, 17'd1);
            chk("bp_hold_id", outId, 2'd0);
            chk("bp_hold_valid", outValid, 1'b1);
            chk("bp_hold_grant", grant, 4'b0000);
        end
        outReady = 1'b1;
        tick();
        chk("bp_rel_valid", outValid, 1'b0);
        chk("bp_rel_grant", grant, 4'b0000);
        tick();
        chk("bp_next_grant", grant, 4'b0010);
        req = '0;
        tick();
        tick();

        // Reset while a result is held, after a table write.
        cfgWe   = 1'b1;
        cfgAddr = 2'd1;
        cfgData = 17'h00007;
        tick();
        cfgWe    = 1'b0;
        req      = 4'b1000;
        code     = 8'b0100_0000;
        outReady = 1'b0;
        tick();
        chk("mr_grant", grant, 4'b1000);
        req = '0;
        tick();
        chk("mr_out", out, 17'd7);
        rst = 1'b1;
        tick();
        chk("mr_valid", outValid, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_grant0", grant, 4'b0000);
        rst      = 1'b0;
        outReady = 1'b1;
        serve(4'b1010, 8'b0000_0100, 4'b0010, 17'd1, 2'd1);

        // Randomized traffic, checked by the model only.
        for (int n = 0; n < 3000; n++) begin
            req      = 4'($urandom);
            code     = 8'($urandom);
            outReady = ($urandom % 4) != 0;
            cfgWe    = ($urandom % 8) == 0;
            cfgAddr  = 2'($urandom);
            cfgData  = 17'($urandom);
            rst      = ($urandom % 300) == 0;
            tick();
        end
        rst   = 1'b0;
        cfgWe = 1'b0;
        req   = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_arbiter.md
# decode_arbiter

Round-robin arbiter and sequencer that shares one 2-bit-code-to-17-bit-value lookup decoder among four requesters. The lookup table is runtime-configurable and resets to the standard binary-to-digit mapping. The block sits between the requesting units and the downstream consumer of decoded values. It serialises requests, tags each result with the requester ID, and holds each result under a valid/ready handshake.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (fixed at 4; ID is 2 bits)
- CODE_W, 2, width of each requester's code
- OUT_W, 17, width of a decoded value / table entry

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester request; level, held until granted
- code  input  NUM_REQ*CODE_W  packed codes, requester i at bits [2i+1:2i]
- grant  output  NUM_REQ  one-hot, one-cycle pulse when a request is accepted
- cfgWe  input  1  table write enable
- cfgAddr  input  CODE_W  table entry to write
- cfgData  input  OUT_W  value written to entry cfgAddr
- out  output  OUT_W  decoded value
- outId  output  2  index of the requester that owns out
- outValid  output  1  out/outId valid
- outReady  input  1  consumer accepts out when high with outValid
- busy  output  1  high whenever state is not IDLE

## Operation
- Table: 4 × OUT_W registers. Reset contents: entry0=0, entry1=1, entry2=0, entry3=1.
- cfgWe=1 writes cfgData to entry cfgAddr at the clock edge. Writes are allowed in any state.
- FSM states: IDLE, LOOKUP, RESP.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick the winner by round-robin, starting the search at ptr (ptr, ptr+1, … mod 4).
  - Latch the winner's code and ID. Pulse grant[winner] for one cycle. Go to LOOKUP.
- LOOKUP:
  - Register table[latched code] into out and winner into outId.
  - Set outValid=1. Set ptr=winner+1 mod 4. Go to RESP.
- RESP:
  - Hold out, outId and outValid stable while outReady=0.
  - When outReady=1, clear outValid at that edge and go to IDLE.
- Config-write collision: the table is read before it is written.
  - A write to the addressed entry in the LOOKUP cycle leaves out carrying the old value; the new value applies to later lookups.
  - A write during RESP does not change the out already held.
- Requesters are sampled only in IDLE. A req deasserted before its grant is simply lost; no queueing.
- Unused codes: none. All 4 codes are valid table addresses.

## Timing
- Reset values: state=IDLE, ptr=0, grant=0, out=0, outId=0, outValid=0, busy=0, table=default contents.
- Reset asserted in any state takes effect on the next edge: the in-flight result is discarded and any configured table values are lost.
- Cycle 0: IDLE with req sampled. grant pulse and busy=1 appear in cycle 1 (LOOKUP).
- outValid=1 from cycle 2 (RESP).
- Minimum service interval: 3 cycles per request with outReady held high, since IDLE is always re-entered.
- grant is never high in two consecutive cycles.
- grant is high in exactly the LOOKUP cycle, together with busy=1 and outValid=0.
- Requester order with all four req held high, starting from ptr=0: 0,1,2,3,0,…
- Back-pressure: outReady may stay low indefinitely. No new grant is issued until the handshake completes.
- outReady while outValid=0 is ignored.

## Test plan
- Reset then defaults: req=0001 with code0=11 → grant=0001 in cycle 1; out=1, outId=0, outValid=1 in cycle 2. With outReady=1, outValid=0 in cycle 3.
- Round-robin fairness: all req=1111, codes 00,01,10,11, outReady=1 → outId sequence 0,1,2,3,0. Outs are 0,1,0,1. Each grant is spaced by 3 cycles.
- Configuration: write cfgAddr=10, cfgData=17'h1ABCD in IDLE, then request code 10 → out=17'h1ABCD. Entries 00, 01 and 11 stay unchanged.
- Collision: write entry 01=17'h00005 in the LOOKUP cycle of a code-01 request → out=1. The next code-01 lookup gives out=5.
- Back-pressure: outReady=0 for 10 cycles in RESP, with other reqs active → out, outId and outValid stay stable and no grant occurs. Release outReady → next grant goes to requester ptr onward.
- Reset mid-operation: assert rst in RESP after a table write → next cycle outValid=0, busy=0, state=IDLE, table restored to 0,1,0,1, and the first grant after reset goes to the lowest active index.
